// File: rtl/rv_pkg.sv
// rv_pkg: shared write-back types and commit-register geometry
package rv_pkg;
  localparam int RV = 64;
  localparam int NCOMMIT = 32;
  localparam int LNCOMMIT = 5;
  localparam int NHART = 1;
  typedef struct packed {
    logic                valid;
    logic [NHART-1:0]    hart;
    logic [LNCOMMIT-1:0] rd;
    logic [RV-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/alu_wb_queue_ram.sv
// alu_wb_queue_ram: entry flop array with two write ports, one read port and kill-driven valid clear
module alu_wb_queue_ram
  import rv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LDEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCOMMIT-1:0] kill_i,
  input  logic               we0_i,
  input  logic [LDEPTH-1:0]  waddr0_i,
  input  wb_entry_t          wdata0_i,
  input  logic               we1_i,
  input  logic [LDEPTH-1:0]  waddr1_i,
  input  wb_entry_t          wdata1_i,
  input  logic [LDEPTH-1:0]  raddr_i,
  output wb_entry_t          rdata_o
);
  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  // Incoming writes were already screened against the kill vector, so they override the clear.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      mem_d[i].valid = mem_q[i].valid & ~kill_i[mem_q[i].rd];
    end
    if (we0_i) mem_d[waddr0_i] = wdata0_i;
    if (we1_i) mem_d[waddr1_i] = wdata1_i;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/alu_wb_queue.sv
// alu_wb_queue: in-order ALU result buffer feeding one commit-register write port
module alu_wb_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LDEPTH = 3,
  parameter int STALL_MARGIN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NHART-1:0]    in0_makes_rd,
  input  logic [LNCOMMIT-1:0] in0_rd,
  input  logic [RV-1:0]       in0_result,
  input  logic [NHART-1:0]    in1_makes_rd,
  input  logic [LNCOMMIT-1:0] in1_rd,
  input  logic [RV-1:0]       in1_result,
  input  logic [NCOMMIT-1:0]  commit_kill,
  input  logic                wr_ready,
  output logic [NHART-1:0]    wr_enable,
  output logic [LNCOMMIT-1:0] wr_addr,
  output logic [RV-1:0]       wr_data,
  output logic                stall,
  output logic                overflow
);
  localparam logic [LDEPTH:0] DEPTH_C = (LDEPTH+1)'(DEPTH);
  localparam logic [LDEPTH:0] STALL_AT = (LDEPTH+1)'(DEPTH - STALL_MARGIN);
  logic [LDEPTH:0] head_q, head_d, tail_q, tail_d, tail1, count, free;
  logic stall_q, stall_d, overflow_q, overflow_d;
  logic v0, v1, acc0, acc1, pop;
  wb_entry_t head_e, e0, e1;
  assign count = tail_q - head_q;
  assign pop = (count != '0) && (!head_e.valid || wr_ready);
  assign v0 = |in0_makes_rd && !commit_kill[in0_rd];
  assign v1 = |in1_makes_rd && !commit_kill[in1_rd];
  // Free space counts the slot released by this cycle's pop.
  assign free = DEPTH_C - count + {{LDEPTH{1'b0}}, pop};
  assign acc0 = v0 && (free != '0);
  assign acc1 = v1 && (free > {{LDEPTH{1'b0}}, acc0});
  assign tail1 = tail_q + {{LDEPTH{1'b0}}, acc0};
  assign tail_d = tail1 + {{LDEPTH{1'b0}}, acc1};
  assign head_d = head_q + {{LDEPTH{1'b0}}, pop};
  assign stall_d = (tail_d - head_d) >= STALL_AT;
  assign overflow_d = overflow_q || (v0 && !acc0) || (v1 && !acc1);
  assign e0 = '{valid: 1'b1, hart: in0_makes_rd, rd: in0_rd, data: in0_result};
  assign e1 = '{valid: 1'b1, hart: in1_makes_rd, rd: in1_rd, data: in1_result};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      stall_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      stall_q <= stall_d;
      overflow_q <= overflow_d;
    end
  alu_wb_queue_ram #(.DEPTH(DEPTH), .LDEPTH(LDEPTH)) u_ram (
    .clk(clk),
    .rst(reset),
    .kill_i(commit_kill),
    .we0_i(acc0),
    .waddr0_i(tail_q[LDEPTH-1:0]),
    .wdata0_i(e0),
    .we1_i(acc1),
    .waddr1_i(tail1[LDEPTH-1:0]),
    .wdata1_i(e1),
    .raddr_i(head_q[LDEPTH-1:0]),
    .rdata_o(head_e)
  );
  assign wr_enable = (count != '0 && head_e.valid) ? head_e.hart : '0;
  assign wr_addr = head_e.rd;
  assign wr_data = head_e.data;
  assign stall = stall_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_alu_wb_queue.sv
// tb_alu_wb_queue: directed stimulus with a scoreboard monitor on the write port
module tb_alu_wb_queue;
  import rv_pkg::*;
  logic clk = 1'b0, reset = 1'b1, wr_ready = 1'b0;
  logic [NHART-1:0] in0_makes_rd = '0, in1_makes_rd = '0, wr_enable;
  logic [LNCOMMIT-1:0] in0_rd = '0, in1_rd = '0, wr_addr;
  logic [RV-1:0] in0_result = '0, in1_result = '0, wr_data;
  logic [NCOMMIT-1:0] commit_kill = '0;
  logic stall, overflow;
  int checks = 0, errors = 0, sent;
  logic [LNCOMMIT+RV-1:0] exp_q [$];

  alu_wb_queue dut (
    .clk(clk), .reset(reset),
    .in0_makes_rd(in0_makes_rd), .in0_rd(in0_rd), .in0_result(in0_result),
    .in1_makes_rd(in1_makes_rd), .in1_rd(in1_rd), .in1_result(in1_result),
    .commit_kill(commit_kill), .wr_ready(wr_ready),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .stall(stall), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [LNCOMMIT+RV-1:0] e;
    if (!reset && wr_enable != '0 && wr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e || wr_enable !== 1'b1) begin
          errors++;
          $display("FAIL write_order: got en=%0b rd=%0d data=%0h, required en=1 rd=%0d data=%0h",
                   wr_enable, wr_addr, wr_data, e[RV+LNCOMMIT-1:RV], e[RV-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic issue(input logic a0, input logic [4:0] r0, input logic [63:0] d0, input logic t0,
                       input logic a1, input logic [4:0] r1, input logic [63:0] d1, input logic t1);
    in0_makes_rd = a0; in0_rd = r0; in0_result = d0;
    in1_makes_rd = a1; in1_rd = r1; in1_result = d1;
    if (a0 && t0) exp_q.push_back({r0, d0});
    if (a1 && t1) exp_q.push_back({r1, d1});
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    step();
    idle();
    wr_ready = 1'b1;
    while (exp_q.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    step();
    chk("drain_done", 64'(exp_q.size()), 0);
    chk("drain_idle", 64'(wr_enable), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    #2;
    chk("reset_wr_enable", 64'(wr_enable), 0);
    chk("reset_stall", 64'(stall), 0);
    chk("reset_overflow", 64'(overflow), 0);
    chk("reset_wr_addr", 64'(wr_addr), 0);
    step();
    reset = 1'b0;

    // single push
    step(); issue(1, 5, 64'h1234, 1, 0, 0, 0, 0); wr_ready = 1'b1;
    step(); idle();
    chk("single_en", 64'(wr_enable), 1);
    chk("single_addr", 64'(wr_addr), 5);
    chk("single_data", wr_data, 64'h1234);
    step();
    chk("single_empty", 64'(wr_enable), 0);

    // dual push ordering
    step(); issue(1, 3, 64'hAAAA, 1, 1, 7, 64'hBBBB, 1);
    step(); idle();
    chk("dual_first", 64'(wr_addr), 3);
    step();
    chk("dual_second", 64'(wr_addr), 7);
    step();
    chk("dual_empty", 64'(wr_enable), 0);

    // kill: queue rd 2, 9, 4 then kill rd 9, with a rd 9 input in the kill cycle
    wr_ready = 1'b0;
    step(); issue(1, 2, 64'h22, 1, 1, 9, 64'h99, 0);
    step(); issue(1, 4, 64'h44, 1, 0, 0, 0, 0);
    step(); issue(1, 9, 64'h999, 0, 0, 0, 0, 0); commit_kill = 32'h1 << 9;
    step(); idle(); commit_kill = '0; wr_ready = 1'b1;
    chk("kill_first", 64'(wr_addr), 2);
    step();
    chk("kill_discard", 64'(wr_enable), 0);
    step();
    chk("kill_last", 64'(wr_addr), 4);
    step();
    chk("kill_empty", 64'(wr_enable), 0);

    // wrap-around: 20 single pushes respecting stall, wr_ready toggling
    sent = 0;
    for (int c = 0; c < 400 && sent < 20; c++) begin
      step();
      wr_ready = c[0];
      if (!stall) begin
        issue(1, 5'(sent), 64'h100 + 64'(sent), 1, 0, 0, 0, 0);
        sent++;
      end else idle();
    end
    chk("wrap_sent", 64'(sent), 20);
    drain(60);
    chk("wrap_no_overflow", 64'(overflow), 0);

    // backpressure, stall and overflow
    wr_ready = 1'b0;
    step(); issue(1, 10, 64'hA0, 1, 1, 11, 64'hA1, 1);
    step(); chk("bp_stall_at2", 64'(stall), 0); issue(1, 12, 64'hA2, 1, 1, 13, 64'hA3, 1);
    step(); chk("bp_stall_at4", 64'(stall), 1); issue(1, 14, 64'hA4, 1, 1, 15, 64'hA5, 1);
    step(); issue(1, 16, 64'hA6, 1, 1, 17, 64'hA7, 1);
    step(); chk("bp_full_no_overflow", 64'(overflow), 0); issue(1, 18, 64'hA8, 0, 0, 0, 0, 0);
    step(); idle();
    chk("bp_overflow", 64'(overflow), 1);
    chk("bp_stall_full", 64'(stall), 1);
    drain(40);
    chk("bp_stall_clear", 64'(stall), 0);
    chk("bp_overflow_sticky", 64'(overflow), 1);

    // async reset with 5 entries queued
    wr_ready = 1'b0;
    step(); issue(1, 20, 64'hC0, 0, 1, 21, 64'hC1, 0);
    step(); issue(1, 22, 64'hC2, 0, 1, 23, 64'hC3, 0);
    step(); issue(1, 24, 64'hC4, 0, 0, 0, 0, 0);
    step(); idle();
    chk("rst_pre_stall", 64'(stall), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_enable", 64'(wr_enable), 0);
    chk("rst_stall", 64'(stall), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_wr_data", wr_data, 0);
    exp_q.delete();
    step(); step();
    reset = 1'b0; wr_ready = 1'b1;
    repeat (5) step();
    chk("rst_no_stale", 64'(wr_enable), 0);
    chk("rst_post_stall", 64'(stall), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
